load_order_queue: RTL and testbench

Parametrised load-ordering queue in the memory stage of the out-of-order core. It holds every issued load's address and ROB tag until retirement. It checks each executing store against all younger in-flight loads and reports the oldest violating load for replay. It also flags out-of-range load addresses. It supersedes the fixed 32-entry load buffer with wrap-safe ROB age comparison, a full/ready handshake, word-granular overlap and a reported violation tag.

---
 rtl/load_order_queue.sv | 184 ++++++++++++++++++
 tb/tb_load_order_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/load_order_queue.sv
`default_nettype none
// ============================================================================
// Module   : load_order_queue
// Purpose  : Load-ordering queue for the memory stage. Holds every issued
//            load (ROB tag + word address) until it retires, checks each
//            executing store against all younger in-flight loads and reports
//            the oldest violating load. Flags illegal load addresses.
// Ports    : clk, reset (async, active-high), flush (sync clear)
//            rob_head_tag            - age origin for wrap-safe ordering
//            alloc_valid/tag/addr    - load allocation, alloc_ready = !full
//            store_valid/tag/addr    - store ordering check
//            retire_valid/tag        - load retirement
//            violation/violation_tag - registered pulse + oldest offender tag
//            addr_exception          - registered pulse, load addr > limit
//            count/full/empty        - occupancy
// Revision : 1.0 - initial release
// ============================================================================
module load_order_queue #(
  parameter int          DEPTH      = 16,
  parameter int          AW         = 32,
  parameter int          TW         = 6,
  parameter int          GRAN       = 2,
  parameter int unsigned ADDR_LIMIT = 2048
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [TW-1:0]              rob_head_tag,
  input  logic                       alloc_valid,
  input  logic [TW-1:0]              alloc_tag,
  input  logic [AW-1:0]              alloc_addr,
  output logic                       alloc_ready,
  input  logic                       store_valid,
  input  logic [TW-1:0]              store_tag,
  input  logic [AW-1:0]              store_addr,
  input  logic                       retire_valid,
  input  logic [TW-1:0]              retire_tag,
  output logic                       violation,
  output logic [TW-1:0]              violation_tag,
  output logic                       addr_exception,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int            c_IW         = $clog2(DEPTH);
  localparam int            c_CW         = c_IW + 1;
  // Bits below GRAN never take part in the overlap compare.
  localparam logic [AW-1:0] c_ADDR_MASK  = {AW{1'b1}} << GRAN;
  localparam logic [AW-1:0] c_ADDR_LIMIT = AW'(ADDR_LIMIT);

  logic              r_valid [DEPTH];
  logic [TW-1:0]     r_tag   [DEPTH];
  logic [AW-1:0]     r_addr  [DEPTH];
  logic [c_CW-1:0]   r_count;
  logic              r_violation;
  logic [TW-1:0]     r_violation_tag;
  logic              r_addr_exception;

  logic              w_full;
  logic              w_addr_bad;
  logic              w_alloc_ok;
  logic              w_addr_exc;
  logic              w_free_found;
  logic [c_IW-1:0]   w_free_idx;
  logic              w_ret_hit;
  logic [c_IW-1:0]   w_ret_idx;
  logic [TW-1:0]     w_store_age;
  logic              w_hit_found;
  logic [TW-1:0]     w_hit_age;
  logic [TW-1:0]     w_hit_tag;

  // Distance from the ROB head, modulo 2^TW: the only wrap-safe ordering.
  function automatic logic [TW-1:0] f_age(input logic [TW-1:0] t,
                                          input logic [TW-1:0] head);
    return t - head;
  endfunction

  assign w_full      = (r_count == c_CW'(DEPTH));
  assign alloc_ready = ~w_full;
  assign w_addr_bad  = (alloc_addr > c_ADDR_LIMIT);
  assign w_alloc_ok  = alloc_valid && alloc_ready && !w_addr_bad;
  assign w_addr_exc  = alloc_valid && alloc_ready && w_addr_bad;

  // Lowest-index free entry (scan high to low so the lowest wins).
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = c_IW'(i);
      end
    end
  end

  // Tags are unique among in-flight loads, so at most one entry hits.
  always_comb begin
    w_ret_hit = 1'b0;
    w_ret_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (retire_valid && r_valid[i] && (r_tag[i] == retire_tag)) begin
        w_ret_hit = 1'b1;
        w_ret_idx = c_IW'(i);
      end
    end
  end

  // Store check over the pre-retire state plus the same-cycle allocation;
  // keep the matching load with the smallest age (oldest younger load).
  always_comb begin
    w_store_age = f_age(store_tag, rob_head_tag);
    w_hit_found = 1'b0;
    w_hit_age   = '0;
    w_hit_tag   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (store_valid && r_valid[i] &&
          (((r_addr[i] ^ store_addr) & c_ADDR_MASK) == '0) &&
          (f_age(r_tag[i], rob_head_tag) > w_store_age)) begin
        if (!w_hit_found || (f_age(r_tag[i], rob_head_tag) < w_hit_age)) begin
          w_hit_found = 1'b1;
          w_hit_age   = f_age(r_tag[i], rob_head_tag);
          w_hit_tag   = r_tag[i];
        end
      end
    end
    if (store_valid && w_alloc_ok &&
        (((alloc_addr ^ store_addr) & c_ADDR_MASK) == '0) &&
        (f_age(alloc_tag, rob_head_tag) > w_store_age)) begin
      if (!w_hit_found || (f_age(alloc_tag, rob_head_tag) < w_hit_age)) begin
        w_hit_found = 1'b1;
        w_hit_age   = f_age(alloc_tag, rob_head_tag);
        w_hit_tag   = alloc_tag;
      end
    end
  end

  // Control state: valid bits, occupancy and the reported pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
      r_count          <= '0;
      r_violation      <= 1'b0;
      r_violation_tag  <= '0;
      r_addr_exception <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
      r_count          <= '0;
      r_violation      <= 1'b0;
      r_violation_tag  <= '0;
      r_addr_exception <= 1'b0;
    end else begin
      // The allocated slot is free in the registered state and the retired
      // slot is valid, so the two writes never target the same entry.
      if (w_alloc_ok && w_free_found) r_valid[w_free_idx] <= 1'b1;
      if (w_ret_hit)                  r_valid[w_ret_idx]  <= 1'b0;
      case ({w_alloc_ok, w_ret_hit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_violation      <= w_hit_found;
      if (w_hit_found) r_violation_tag <= w_hit_tag;
      r_addr_exception <= w_addr_exc;
    end
  end

  // Payload storage needs no reset: it is only read behind a valid bit.
  always_ff @(posedge clk) begin
    if (!flush && w_alloc_ok && w_free_found) begin
      r_tag[w_free_idx]  <= alloc_tag;
      r_addr[w_free_idx] <= alloc_addr & c_ADDR_MASK;
    end
  end

  assign violation      = r_violation;
  assign violation_tag  = r_violation_tag;
  assign addr_exception = r_addr_exception;
  assign count          = r_count;
  assign full           = w_full;
  assign empty          = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_load_order_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_order_queue
// Purpose  : Directed self-checking bench for load_order_queue with
//            hand-computed expected values (DEPTH=16, TW=6, GRAN=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_order_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [5:0]  rob_head_tag;
  logic        alloc_valid;
  logic [5:0]  alloc_tag;
  logic [31:0] alloc_addr;
  logic        alloc_ready;
  logic        store_valid;
  logic [5:0]  store_tag;
  logic [31:0] store_addr;
  logic        retire_valid;
  logic [5:0]  retire_tag;
  logic        violation;
  logic [5:0]  violation_tag;
  logic        addr_exception;
  logic [4:0]  count;
  logic        full;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  load_order_queue #(
    .DEPTH(16), .AW(32), .TW(6), .GRAN(2), .ADDR_LIMIT(2048)
  ) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .rob_head_tag(rob_head_tag),
    .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .alloc_addr(alloc_addr),
    .alloc_ready(alloc_ready),
    .store_valid(store_valid), .store_tag(store_tag), .store_addr(store_addr),
    .retire_valid(retire_valid), .retire_tag(retire_tag),
    .violation(violation), .violation_tag(violation_tag),
    .addr_exception(addr_exception), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flush        = 1'b0;
    alloc_valid  = 1'b0;
    store_valid  = 1'b0;
    retire_valid = 1'b0;
  endtask

  task automatic do_alloc(input logic [5:0] t, input logic [31:0] a);
    alloc_valid = 1'b1; alloc_tag = t; alloc_addr = a;
    tick(); clr();
  endtask

  task automatic do_store(input logic [5:0] t, input logic [31:0] a);
    store_valid = 1'b1; store_tag = t; store_addr = a;
    tick(); clr();
  endtask

  task automatic do_retire(input logic [5:0] t);
    retire_valid = 1'b1; retire_tag = t;
    tick(); clr();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick(); clr();
  endtask

  initial begin
    reset = 1'b1; rob_head_tag = '0;
    alloc_tag = '0; alloc_addr = '0; store_tag = '0; store_addr = '0;
    retire_tag = '0;
    clr();
    repeat (2) tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ready", 32'(alloc_ready), 1);
    chk("rst_viol", 32'(violation), 0);
    chk("rst_vtag", 32'(violation_tag), 0);
    chk("rst_aexc", 32'(addr_exception), 0);
    reset = 1'b0;

    // Ordering violation, head = 0
    do_alloc(6'd5, 32'h100);
    do_alloc(6'd3, 32'h104);
    chk("ord_count", 32'(count), 2);
    do_store(6'd2, 32'h106);
    chk("ord_viol", 32'(violation), 1);
    chk("ord_vtag", 32'(violation_tag), 3);
    tick();
    chk("ord_pulse", 32'(violation), 0);
    chk("ord_hold", 32'(violation_tag), 3);
    do_alloc(6'd7, 32'h104);
    do_store(6'd2, 32'h104);
    chk("oldest_viol", 32'(violation), 1);
    chk("oldest_vtag", 32'(violation_tag), 3);
    do_store(6'd6, 32'h104);
    chk("younger_only_vtag", 32'(violation_tag), 7);
    do_store(6'd6, 32'h100);
    chk("older_load_viol", 32'(violation), 0);
    chk("older_load_hold", 32'(violation_tag), 7);
    do_store(6'd4, 32'h100);
    chk("word_viol_vtag", 32'(violation_tag), 5);
    do_retire(6'd3);
    chk("retire_count", 32'(count), 2);
    do_retire(6'd50);
    chk("retire_miss", 32'(count), 2);
    do_flush();
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_vtag", 32'(violation_tag), 0);

    // Tag wrap-around, head = 60
    rob_head_tag = 6'd60;
    do_alloc(6'd1, 32'h40);
    do_store(6'd62, 32'h40);
    chk("wrap_viol", 32'(violation), 1);
    chk("wrap_vtag", 32'(violation_tag), 1);
    do_store(6'd2, 32'h40);
    chk("wrap_noviol", 32'(violation), 0);
    // Same-cycle allocation is in the candidate set
    alloc_valid = 1'b1; alloc_tag = 6'd0;  alloc_addr = 32'h80;
    store_valid = 1'b1; store_tag = 6'd63; store_addr = 32'h80;
    tick(); clr();
    chk("bypass_viol", 32'(violation), 1);
    chk("bypass_vtag", 32'(violation_tag), 0);
    chk("bypass_count", 32'(count), 2);
    do_flush();

    // Full handling, head = 0
    rob_head_tag = 6'd0;
    for (int i = 1; i <= 16; i++) do_alloc(6'(i), 32'h200 + 32'(4 * i));
    chk("full_count", 32'(count), 16);
    chk("full_full", 32'(full), 1);
    chk("full_ready", 32'(alloc_ready), 0);
    chk("full_empty", 32'(empty), 0);
    do_alloc(6'd20, 32'h300);
    chk("full_ignore", 32'(count), 16);
    retire_valid = 1'b1; retire_tag = 6'd5;
    store_valid  = 1'b1; store_tag  = 6'd19; store_addr = 32'h300;
    tick(); clr();
    chk("ignored_not_stored", 32'(violation), 0);
    chk("free_count", 32'(count), 15);
    chk("free_ready", 32'(alloc_ready), 1);
    do_alloc(6'd20, 32'h300);
    chk("refill_count", 32'(count), 16);
    chk("refill_full", 32'(full), 1);
    // Same-cycle retire does not free a slot for a same-cycle alloc
    alloc_valid  = 1'b1; alloc_tag  = 6'd21; alloc_addr = 32'h304;
    retire_valid = 1'b1; retire_tag = 6'd6;
    tick(); clr();
    chk("ret_alloc_full", 32'(count), 15);
    do_store(6'd19, 32'h304);
    chk("ret_alloc_nostore", 32'(violation), 0);
    do_flush();

    // Address limit
    do_alloc(6'd1, 32'd2049);
    chk("aexc_pulse", 32'(addr_exception), 1);
    chk("aexc_count", 32'(count), 0);
    tick();
    chk("aexc_clear", 32'(addr_exception), 0);
    do_alloc(6'd2, 32'd2048);
    chk("limit_count", 32'(count), 1);
    chk("limit_aexc", 32'(addr_exception), 0);
    alloc_valid  = 1'b1; alloc_tag  = 6'd3; alloc_addr = 32'h10;
    retire_valid = 1'b1; retire_tag = 6'd2;
    tick(); clr();
    chk("alloc_ret_net", 32'(count), 1);

    // Flush overrides a matching store
    flush = 1'b1;
    store_valid = 1'b1; store_tag = 6'd1; store_addr = 32'h10;
    tick(); clr();
    chk("flush_store_viol", 32'(violation), 0);
    chk("flush_store_count", 32'(count), 0);

    // Asynchronous reset mid-traffic
    for (int i = 1; i <= 5; i++) do_alloc(6'(i), 32'(32 * i));
    chk("pre_rst_count", 32'(count), 5);
    do_store(6'd0, 32'h20);
    chk("pre_rst_viol", 32'(violation), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_viol", 32'(violation), 0);
    chk("arst_vtag", 32'(violation_tag), 0);
    tick();
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
